div8: RTL

Sequential 8-bit unsigned restoring divider, the inverse-direction companion to the lab's 8-bit ripple-carry adder. Each iteration runs one trial subtraction through an 8-bit ripple-borrow subtractor built from the same full-adder cells. The block produces a quotient and remainder over 8 iteration cycles. A start/busy/done handshake lets a simple controller or testbench drive it.

---
 rtl/div8_pkg.sv | 14 +
 rtl/sub8.sv | 26 ++
 rtl/div8.sv | 123 ++++++++++++
 3 files changed

// File: rtl/div8_pkg.sv
// Shared constants for the 8-bit restoring divider: operand width,
// final iteration index and FSM state encoding.
package div8_pkg;

  localparam int WIDTH = 8;

  // Counter value during the eighth and last RUN iteration
  localparam logic [2:0] ITER_LAST = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sub8.sv
// 8-bit ripple-borrow subtractor built from full-adder cells:
// a + ~b + 1, with borrow_out being the inverted final carry.
module sub8
  import div8_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_b_inv;

  assign w_b_inv    = ~b;
  assign w_carry[0] = 1'b1;

  // One full-adder cell per bit, carry rippling upward
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign diff[i]      = a[i] ^ w_b_inv[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & w_b_inv[i]) | (w_carry[i] & (a[i] ^ w_b_inv[i]));
  end

  assign borrow_out = ~w_carry[WIDTH];

endmodule

// File: rtl/div8.sv
// Sequential 8-bit unsigned restoring divider. One trial subtraction per
// RUN cycle, eight cycles per result, start/busy/done handshake.
module div8
  import div8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  logic [1:0]       r_state;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic             w_ok;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;

  // A new request is only taken when not iterating
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_state == ST_RUN) && (r_cnt == ITER_LAST);

  // Partial remainder shifted left with the next dividend bit brought in;
  // the bit shifted out of R (R[7]) is the ninth bit of the trial operand.
  assign w_shift = {r_r[WIDTH-2:0], r_q[WIDTH-1]};

  sub8 u_sub8 (
    .a          (w_shift),
    .b          (r_d),
    .diff       (w_diff),
    .borrow_out (w_borrow)
  );

  // A set R[7] means the 9-bit trial operand already exceeds D, so the
  // 8-bit difference is correct modulo 256 even though it borrows.
  assign w_ok     = r_r[WIDTH-1] | ~w_borrow;
  assign w_r_next = w_ok ? w_diff : w_shift;
  assign w_q_next = {r_q[WIDTH-2:0], w_ok};

  // Working registers: load on accept, shift/restore each RUN cycle
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q <= dividend;
      r_d <= divisor;
      r_r <= '0;
    end else if (r_state == ST_RUN) begin
      r_q <= w_q_next;
      r_r <= w_r_next;
    end
  end

  // FSM, iteration counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (divisor == '0) begin
          r_state <= ST_DONE;
          r_quot  <= '1;
          r_rem   <= dividend;
          r_dbz   <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end else begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
          r_dbz   <= 1'b0;
          r_busy  <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_RUN: begin
            r_cnt <= r_cnt + 3'd1;
            if (w_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_quot  <= w_q_next;
              r_rem   <= w_r_next;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          ST_IDLE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule
